// File: rtl/spi_word_engine.sv
// spi_word_engine
//   Word-level SPI master (mode 0, MSB first). It sits between input FIFO A
//   and output FIFO B. One start pulse drains FIFO A. Every word goes out in a
//   single CS-low burst, and every word received on MISO is pushed into FIFO B.
//
//   Build option: define SPI_LOOPBACK_EN to sample the driven spi_mosi instead
//   of the spi_miso pin. Each received word then equals the sent word. Pin
//   timing is the same in both builds.
//
//   All outputs are registered. Each state's action takes effect on the clock
//   edge that leaves that state. This gives the following cycle behaviour:
//     - FIFOA_ren is high during WAIT.
//     - FIFOA_OUT is valid during LOAD.
//     - FIFOB_wen is high during the first GAP cycle.
//     - done is high during the IDLE cycle that follows DONE.
module spi_word_engine #(
  parameter int WORD_W   = 32,  // bits per SPI word and FIFO data width
  parameter int HALF_DIV = 4,   // CLK cycles per SCK half-period (>= 2)
  parameter int GAP_CYC  = 2    // idle-low CLK cycles between words (>= 1)
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] FIFOA_OUT,
  input  logic              FIFOA_empty,
  output logic              FIFOA_ren,
  output logic [WORD_W-1:0] FIFOB_IN,
  output logic              FIFOB_wen,
  input  logic              FIFOB_full,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_cs,
  output logic              busy,
  output logic              done,
  output logic [15:0]       word_cnt
);

  localparam int BIT_W = $clog2(WORD_W + 1);
  localparam int DIV_W = $clog2(HALF_DIV);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_LOAD,
    ST_SHIFT,
    ST_STORE,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  // tx_sr holds only the bits still to be sent. The MSB goes straight from
  // FIFOA_OUT onto spi_mosi in LOAD.
  logic [WORD_W-2:0] tx_sr;
  logic [WORD_W-1:0] rx_sr;

  // Per-cycle strobes decoded by the FSM.
  logic half_end;
  logic sck_rise;
  logic sck_fall;
  logic word_end;
  logic store_go;
  logic gap_done;
  logic burst_end;

  logic miso_src;

`ifdef SPI_LOOPBACK_EN
  // Loopback: sample the bit being driven on spi_mosi. The pin is unused.
  logic unused_miso_pin;
  assign unused_miso_pin = spi_miso;
  assign miso_src        = spi_mosi;
`else
  assign miso_src = spi_miso;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: all clocked state uses non-blocking assignments. Every register
    // then sees the pre-edge values of the others, whatever the block order.
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and per-cycle strobes.
  always_comb begin
    // NOTE: every signal this block drives gets a default first. No path can
    // leave one unassigned, so no latch is inferred.
    next_state = state;
    half_end   = (div_cnt == DIV_LAST);
    sck_rise   = 1'b0;
    sck_fall   = 1'b0;
    word_end   = 1'b0;
    store_go   = 1'b0;
    gap_done   = 1'b0;
    burst_end  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = FIFOA_empty ? ST_DONE : ST_FETCH;
        end
      end

      ST_FETCH: next_state = ST_WAIT;

      ST_WAIT:  next_state = ST_LOAD;

      ST_LOAD:  next_state = ST_SHIFT;

      ST_SHIFT: begin
        sck_rise = half_end && !spi_sck;
        sck_fall = half_end && spi_sck;
        // The word ends on the falling edge after the last rising edge.
        // SCK is therefore already low when STORE begins.
        word_end = sck_fall && (bit_cnt == BIT_LAST);
        if (word_end) begin
          next_state = ST_STORE;
        end
      end

      ST_STORE: begin
        // While FIFO B is full, hold here with SCK low and CS low.
        store_go = !FIFOB_full;
        if (store_go) begin
          next_state = ST_GAP;
        end
      end

      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_done = 1'b1;
          // Words that arrived in FIFO A during the burst join it here.
          if (FIFOA_empty) begin
            burst_end  = 1'b1;
            next_state = ST_DONE;
          end else begin
            next_state = ST_FETCH;
          end
        end
      end

      ST_DONE:  next_state = ST_IDLE;

      default:  next_state = ST_IDLE;
    endcase
  end

  // Registered datapath and outputs: SCK generation, shifting, FIFO strobes
  // and burst status.
  always_ff @(posedge CLK) begin
    if (rst) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      spi_cs    <= 1'b1;
      spi_sck   <= 1'b0;
      spi_mosi  <= 1'b0;
      FIFOA_ren <= 1'b0;
      FIFOB_wen <= 1'b0;
      FIFOB_IN  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      word_cnt  <= '0;
    end else begin
      // Strobe outputs are single-cycle pulses unless re-asserted below.
      FIFOA_ren <= 1'b0;
      FIFOB_wen <= 1'b0;
      done      <= 1'b0;

      // A start that arrives while busy has no effect, because state is
      // not IDLE.
      if (state == ST_IDLE && start) begin
        busy     <= 1'b1;
        word_cnt <= '0;
      end

      if (state == ST_FETCH) begin
        FIFOA_ren <= 1'b1;
      end

      // Present the MSB and drop CS. The first SCK low half-period then
      // starts with valid data on spi_mosi.
      if (state == ST_LOAD) begin
        tx_sr    <= FIFOA_OUT[WORD_W-2:0];
        spi_mosi <= FIFOA_OUT[WORD_W-1];
        spi_cs   <= 1'b0;
        bit_cnt  <= '0;
        div_cnt  <= '0;
      end

      if (state == ST_SHIFT) begin
        if (half_end) begin
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end

      // Sample MISO on the rising edge.
      if (sck_rise) begin
        spi_sck <= 1'b1;
        rx_sr   <= {rx_sr[WORD_W-2:0], miso_src};
        bit_cnt <= bit_cnt + 1'b1;
      end

      // Launch the next MOSI bit on the falling edge. After the last bit,
      // zeros have been shifted in, so spi_mosi rests low.
      if (sck_fall) begin
        spi_sck  <= 1'b0;
        spi_mosi <= tx_sr[WORD_W-2];
        tx_sr    <= {tx_sr[WORD_W-3:0], 1'b0};
      end

      if (store_go) begin
        FIFOB_IN  <= rx_sr;
        FIFOB_wen <= 1'b1;
        gap_cnt   <= '0;
        if (word_cnt != 16'hFFFF) begin
          word_cnt <= word_cnt + 16'd1;
        end
      end

      if (state == ST_GAP && !gap_done) begin
        gap_cnt <= gap_cnt + 1'b1;
      end

      if (burst_end) begin
        spi_cs <= 1'b1;
      end

      if (state == ST_DONE) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_word_engine.sv
// tb_spi_word_engine
//   Directed bench for spi_word_engine. It models FIFO A, FIFO B and an SPI
//   mode-0 slave. The slave shifts out a queued word per SPI word and
//   reassembles the MOSI word seen on each rising SCK edge. All DUT outputs
//   are sampled on the falling CLK edge.
module tb_spi_word_engine;

  localparam int WORD_W   = 32;
  localparam int HALF_DIV = 4;
  localparam int GAP_CYC  = 2;

`ifdef SPI_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              rst;
  logic              start;
  logic [WORD_W-1:0] FIFOA_OUT = '0;
  logic              FIFOA_empty;
  logic              FIFOA_ren;
  logic [WORD_W-1:0] FIFOB_IN;
  logic              FIFOB_wen;
  logic              FIFOB_full;
  logic              spi_sck;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_cs;
  logic              busy;
  logic              done;
  logic [15:0]       word_cnt;

  logic              miso_tie;
  logic              slave_miso = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // FIFO A: tasks write fa_wr and the monitor owns fa_rd.
  logic [31:0] fa_mem [64];
  int          fa_wr = 0;
  int          fa_rd = 0;
  // Slave transmit words: tasks write s_wr and the monitor owns s_rd.
  logic [31:0] s_mem [64];
  int          s_wr = 0;
  int          s_rd = 0;
  // Captured words and event counters, all owned by the monitor.
  logic [31:0] fb_mem [64];
  int          fb_cnt = 0;
  logic [31:0] tx_mem [64];
  int          tx_cnt = 0;
  int          rise_cnt = 0;
  int          cs_fall_cnt = 0;
  int          cs_rise_cnt = 0;
  int          ren_cnt = 0;
  int          done_cnt = 0;
  int          mosi_hi_cnt = 0;

  logic [31:0] s_sr = '0;
  int          s_bits = 0;
  bit          s_loaded = 1'b0;
  logic [31:0] mon_sr = '0;
  int          mon_bits = 0;
  logic        prev_sck = 1'b0;
  logic        prev_cs = 1'b1;

  assign FIFOA_empty = (fa_rd == fa_wr);
  assign spi_miso    = miso_tie ? 1'b1 : slave_miso;

  spi_word_engine #(
    .WORD_W   (WORD_W),
    .HALF_DIV (HALF_DIV),
    .GAP_CYC  (GAP_CYC)
  ) dut (
    .CLK         (CLK),
    .rst         (rst),
    .start       (start),
    .FIFOA_OUT   (FIFOA_OUT),
    .FIFOA_empty (FIFOA_empty),
    .FIFOA_ren   (FIFOA_ren),
    .FIFOB_IN    (FIFOB_IN),
    .FIFOB_wen   (FIFOB_wen),
    .FIFOB_full  (FIFOB_full),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_cs      (spi_cs),
    .busy        (busy),
    .done        (done),
    .word_cnt    (word_cnt)
  );

  always #5 CLK = ~CLK;

  // FIFO models, SPI slave and bus monitor, evaluated on the falling edge.
  always @(negedge CLK) begin
    if (FIFOA_ren === 1'b1) begin
      FIFOA_OUT = fa_mem[fa_rd];
      fa_rd     = fa_rd + 1;
      ren_cnt   = ren_cnt + 1;
    end
    if (FIFOB_wen === 1'b1) begin
      fb_mem[fb_cnt] = FIFOB_IN;
      fb_cnt         = fb_cnt + 1;
    end
    if (done === 1'b1)     done_cnt    = done_cnt + 1;
    if (spi_mosi === 1'b1) mosi_hi_cnt = mosi_hi_cnt + 1;
    if (prev_cs === 1'b1 && spi_cs === 1'b0)   cs_fall_cnt = cs_fall_cnt + 1;
    if (prev_cs === 1'b0 && spi_cs === 1'b1)   cs_rise_cnt = cs_rise_cnt + 1;
    if (prev_sck === 1'b0 && spi_sck === 1'b1) rise_cnt    = rise_cnt + 1;

    if (spi_cs !== 1'b0) begin
      s_loaded = 1'b0;
      s_bits   = 0;
      mon_bits = 0;
    end else begin
      if (!s_loaded) begin
        s_loaded = 1'b1;
        if (s_rd != s_wr) begin s_sr = s_mem[s_rd]; s_rd = s_rd + 1; end
        else s_sr = '0;
      end
      if (prev_sck === 1'b0 && spi_sck === 1'b1) begin
        mon_sr   = {mon_sr[30:0], spi_mosi};
        mon_bits = mon_bits + 1;
        if (mon_bits == 32) begin
          tx_mem[tx_cnt] = mon_sr;
          tx_cnt         = tx_cnt + 1;
          mon_bits       = 0;
        end
      end
      if (prev_sck === 1'b1 && spi_sck === 1'b0) begin
        s_bits = s_bits + 1;
        if (s_bits == 32) begin
          s_bits = 0;
          if (s_rd != s_wr) begin s_sr = s_mem[s_rd]; s_rd = s_rd + 1; end
          else s_sr = '0;
        end else begin
          s_sr = {s_sr[30:0], 1'b0};
        end
      end
    end
    slave_miso = s_sr[31];
    prev_sck   = spi_sck;
    prev_cs    = spi_cs;
  end

  task automatic push_word(input logic [31:0] a_word, input logic [31:0] s_word);
    fa_mem[fa_wr] = a_word;
    fa_wr         = fa_wr + 1;
    s_mem[s_wr]   = s_word;
    s_wr          = s_wr + 1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge CLK);
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; FIFOB_full = 1'b0; miso_tie = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({spi_cs, spi_sck, spi_mosi, FIFOA_ren, FIFOB_wen, busy, done} !== 7'b1000000) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b expected 1000000",
               {spi_cs, spi_sck, spi_mosi, FIFOA_ren, FIFOB_wen, busy, done});
    end
    n_checks++;
    if (FIFOB_IN !== 32'h0) begin n_errors++; $display("FAIL reset_fifob_in: got %h expected 00000000", FIFOB_IN); end
    n_checks++;
    if (word_cnt !== 16'h0) begin n_errors++; $display("FAIL reset_word_cnt: got %0d expected 0", word_cnt); end
    rst = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_single_word;
    int r0, f0, t0, d0;
    bit seen;
    r0 = rise_cnt; f0 = fb_cnt; t0 = tx_cnt; d0 = done_cnt;
    push_word(32'hA5A5_0F0F, 32'hA5A5_0F0F);
    pulse_start();
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    wait_done(1000, seen);
    n_checks++;
    if (!seen) begin n_errors++; $display("FAIL single_done_timeout: got none expected done pulse"); end
    repeat (3) @(negedge CLK);
    n_checks++;
    if (rise_cnt - r0 !== 32) begin n_errors++; $display("FAIL single_rises: got %0d expected 32", rise_cnt - r0); end
    n_checks++;
    if (fb_mem[f0] !== 32'hA5A5_0F0F || fb_cnt - f0 !== 1) begin
      n_errors++; $display("FAIL single_fifob: got %h (%0d writes) expected a5a50f0f (1 write)", fb_mem[f0], fb_cnt - f0);
    end
    n_checks++;
    if (tx_mem[t0] !== 32'hA5A5_0F0F) begin n_errors++; $display("FAIL single_mosi: got %h expected a5a50f0f", tx_mem[t0]); end
    n_checks++;
    if (word_cnt !== 16'd1) begin n_errors++; $display("FAIL single_word_cnt: got %0d expected 1", word_cnt); end
    n_checks++;
    if (done_cnt - d0 !== 1) begin n_errors++; $display("FAIL single_done_pulses: got %0d expected 1", done_cnt - d0); end
    n_checks++;
    if (busy !== 1'b0 || spi_cs !== 1'b1) begin
      n_errors++; $display("FAIL single_idle: got busy=%b cs=%b expected busy=0 cs=1", busy, spi_cs);
    end
  endtask

  task automatic test_miso_high;
    int r0, f0, m0;
    bit seen;
    logic [31:0] exp_rx;
    exp_rx = LOOPBACK ? 32'h0000_0000 : 32'hFFFF_FFFF;
    r0 = rise_cnt; f0 = fb_cnt; m0 = mosi_hi_cnt;
    miso_tie = 1'b1;
    push_word(32'h0000_0000, 32'h0000_0000);
    pulse_start();
    wait_done(1000, seen);
    n_checks++;
    if (!seen) begin n_errors++; $display("FAIL miso_done_timeout: got none expected done pulse"); end
    repeat (3) @(negedge CLK);
    n_checks++;
    if (fb_mem[f0] !== exp_rx) begin n_errors++; $display("FAIL miso_fifob: got %h expected %h", fb_mem[f0], exp_rx); end
    n_checks++;
    if (mosi_hi_cnt - m0 !== 0) begin n_errors++; $display("FAIL miso_mosi_low: got %0d high cycles expected 0", mosi_hi_cnt - m0); end
    n_checks++;
    if (rise_cnt - r0 !== 32) begin n_errors++; $display("FAIL miso_rises: got %0d expected 32", rise_cnt - r0); end
    miso_tie = 1'b0;
  endtask

  task automatic test_back_to_back;
    int r0, f0, t0, d0, cf0, cr0;
    bit seen;
    logic [31:0] a_words [3];
    logic [31:0] s_words [3];
    logic [31:0] exp_rx;
    a_words = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003};
    s_words = '{32'hDEAD_BEEF, 32'h1234_5678, 32'h8000_0001};
    r0 = rise_cnt; f0 = fb_cnt; t0 = tx_cnt; d0 = done_cnt;
    cf0 = cs_fall_cnt; cr0 = cs_rise_cnt;
    for (int i = 0; i < 3; i++) push_word(a_words[i], s_words[i]);
    pulse_start();
    repeat (100) @(negedge CLK);
    pulse_start();
    wait_done(2000, seen);
    n_checks++;
    if (!seen) begin n_errors++; $display("FAIL b2b_done_timeout: got none expected done pulse"); end
    n_checks++;
    if (spi_cs !== 1'b1 || busy !== 1'b0) begin
      n_errors++; $display("FAIL b2b_at_done: got cs=%b busy=%b expected cs=1 busy=0", spi_cs, busy);
    end
    repeat (20) @(negedge CLK);
    n_checks++;
    if (cs_fall_cnt - cf0 !== 1 || cs_rise_cnt - cr0 !== 1) begin
      n_errors++; $display("FAIL b2b_cs_continuous: got falls=%0d rises=%0d expected 1 and 1",
                           cs_fall_cnt - cf0, cs_rise_cnt - cr0);
    end
    n_checks++;
    if (rise_cnt - r0 !== 96) begin n_errors++; $display("FAIL b2b_rises: got %0d expected 96", rise_cnt - r0); end
    n_checks++;
    if (fb_cnt - f0 !== 3) begin n_errors++; $display("FAIL b2b_wen_pulses: got %0d expected 3", fb_cnt - f0); end
    for (int i = 0; i < 3; i++) begin
      exp_rx = LOOPBACK ? a_words[i] : s_words[i];
      n_checks++;
      if (fb_mem[f0 + i] !== exp_rx) begin
        n_errors++; $display("FAIL b2b_fifob_%0d: got %h expected %h", i, fb_mem[f0 + i], exp_rx);
      end
      n_checks++;
      if (tx_mem[t0 + i] !== a_words[i]) begin
        n_errors++; $display("FAIL b2b_mosi_%0d: got %h expected %h", i, tx_mem[t0 + i], a_words[i]);
      end
    end
    n_checks++;
    if (word_cnt !== 16'd3) begin n_errors++; $display("FAIL b2b_word_cnt: got %0d expected 3", word_cnt); end
    n_checks++;
    if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
      n_errors++; $display("FAIL b2b_restart_ignored: got done pulses=%0d busy=%b expected 1 and 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_fifob_full;
    int r0, f0, stall_bad, budget;
    bit seen;
    logic [31:0] exp_rx;
    exp_rx = LOOPBACK ? 32'h3C3C_C3C3 : 32'h0F0F_F0F0;
    r0 = rise_cnt; f0 = fb_cnt;
    push_word(32'h3C3C_C3C3, 32'h0F0F_F0F0);
    FIFOB_full = 1'b1;
    pulse_start();
    budget = 0;
    while (rise_cnt - r0 < 32 && budget < 600) begin @(negedge CLK); budget++; end
    while (spi_sck !== 1'b0 && budget < 600) begin @(negedge CLK); budget++; end
    n_checks++;
    if (budget >= 600) begin n_errors++; $display("FAIL full_reach_store: got timeout expected word end"); end
    stall_bad = 0;
    repeat (50) begin
      @(negedge CLK);
      if (spi_sck !== 1'b0 || spi_cs !== 1'b0 || FIFOB_wen !== 1'b0) stall_bad++;
    end
    n_checks++;
    if (stall_bad !== 0) begin n_errors++; $display("FAIL full_stall: got %0d bad cycles expected 0", stall_bad); end
    n_checks++;
    if (fb_cnt - f0 !== 0 || word_cnt !== 16'd0) begin
      n_errors++; $display("FAIL full_no_write: got writes=%0d word_cnt=%0d expected 0 and 0", fb_cnt - f0, word_cnt);
    end
    FIFOB_full = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (FIFOB_wen !== 1'b1) begin n_errors++; $display("FAIL full_release_wen: got %b expected 1", FIFOB_wen); end
    n_checks++;
    if (FIFOB_IN !== exp_rx) begin n_errors++; $display("FAIL full_release_data: got %h expected %h", FIFOB_IN, exp_rx); end
    wait_done(200, seen);
    n_checks++;
    if (!seen || word_cnt !== 16'd1) begin
      n_errors++; $display("FAIL full_finish: got done=%b word_cnt=%0d expected 1 and 1", seen, word_cnt);
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_empty_start;
    int cf0, ren0, d0;
    cf0 = cs_fall_cnt; ren0 = ren_cnt; d0 = done_cnt;
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || word_cnt !== 16'd0) begin
      n_errors++; $display("FAIL empty_cycle1: got busy=%b done=%b word_cnt=%0d expected 1 0 0", busy, done, word_cnt);
    end
    @(negedge CLK);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_errors++; $display("FAIL empty_cycle2: got done=%b busy=%b expected 1 0", done, busy);
    end
    repeat (5) @(negedge CLK);
    n_checks++;
    if (cs_fall_cnt - cf0 !== 0 || ren_cnt - ren0 !== 0 || done_cnt - d0 !== 1) begin
      n_errors++; $display("FAIL empty_no_activity: got cs_falls=%0d rens=%0d dones=%0d expected 0 0 1",
                           cs_fall_cnt - cf0, ren_cnt - ren0, done_cnt - d0);
    end
    n_checks++;
    if (word_cnt !== 16'd0) begin n_errors++; $display("FAIL empty_word_cnt: got %0d expected 0", word_cnt); end
  endtask

  task automatic test_reset_mid;
    int r0, f0, t0, budget;
    bit seen;
    logic [31:0] exp_rx;
    r0 = rise_cnt; f0 = fb_cnt;
    push_word(32'hC0DE_0001, 32'h1111_1111);
    pulse_start();
    budget = 0;
    while (rise_cnt - r0 < 10 && budget < 300) begin @(negedge CLK); budget++; end
    n_checks++;
    if (budget >= 300) begin n_errors++; $display("FAIL rstmid_reach_bit10: got timeout expected 10 rises"); end
    rst = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({spi_cs, spi_sck, busy, FIFOB_wen, spi_mosi} !== 5'b10000) begin
      n_errors++; $display("FAIL rstmid_outputs: got cs,sck,busy,wen,mosi=%b expected 10000",
                           {spi_cs, spi_sck, busy, FIFOB_wen, spi_mosi});
    end
    rst = 1'b0;
    repeat (300) @(negedge CLK);
    n_checks++;
    if (fb_cnt - f0 !== 0) begin n_errors++; $display("FAIL rstmid_no_write: got %0d writes expected 0", fb_cnt - f0); end
    exp_rx = LOOPBACK ? 32'h5A5A_1234 : 32'h6B6B_0042;
    t0 = tx_cnt;
    push_word(32'h5A5A_1234, 32'h6B6B_0042);
    pulse_start();
    wait_done(1000, seen);
    n_checks++;
    if (!seen) begin n_errors++; $display("FAIL rstmid_restart_timeout: got none expected done pulse"); end
    repeat (3) @(negedge CLK);
    n_checks++;
    if (fb_mem[f0] !== exp_rx || fb_cnt - f0 !== 1) begin
      n_errors++; $display("FAIL rstmid_restart_fifob: got %h (%0d writes) expected %h (1 write)", fb_mem[f0], fb_cnt - f0, exp_rx);
    end
    n_checks++;
    if (tx_mem[t0] !== 32'h5A5A_1234 || word_cnt !== 16'd1) begin
      n_errors++; $display("FAIL rstmid_restart_tx: got %h word_cnt=%0d expected 5a5a1234 and 1", tx_mem[t0], word_cnt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected completion within 2 ms");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; FIFOB_full = 1'b0; miso_tie = 1'b0;
    @(negedge CLK);
    test_reset();
    test_single_word();
    test_miso_high();
    test_back_to_back();
    test_fifob_full();
    test_empty_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
